// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the multicycle RISC-V core. Walks one instruction at
// a time through fetch/decode/execute/memory/writeback and drives every
// datapath select and enable, stalling on the memory ready handshake.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic       funct3_0,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic [3:0] state,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  state_e state_q;
  state_e state_d;

  // Immediate format follows the opcode directly, independent of state.
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE:               imm_src = 2'b11;
      OP_BR:                  imm_src = 2'b10;
      OP_I, OP_LOAD, OP_JALR: imm_src = 2'b01;
      default:                imm_src = 2'b00;
    endcase
  endfunction

  // Next-state selection; memory states hold until mem_ready completes the access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      // JALR redirects the PC first, then LINK forms OldPC+4 for rd, so rs1
      // has already been consumed before rd is written.
      S_JALR:     state_d = S_LINK;
      S_LINK:     state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register; reset always lands in FETCH and abandons any pending access.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Output decode of the current state; reset forces every output low at once
  // so an in-flight memory request is dropped in the reset cycle itself.
  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    ImmSrc    = 2'b00;
    state     = 4'd0;
    illegal   = 1'b0;
    if (!rst) begin
      state  = state_q;
      ImmSrc = imm_src(Op);
      case (state_q)
        S_FETCH: begin
          MemReq    = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_MEMREAD: begin
          MemReq = 1'b1;
          AdrSrc = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          MemReq   = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b10;
        end
        S_EXECI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b11;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b01;
          PCWrite = Zero ^ funct3_0;
        end
        S_JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
        end
        S_JALR: begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
        end
        S_LINK: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
        end
        S_TRAP: begin
          illegal = 1'b1;
        end
        default: begin
          ImmSrc = 2'b00;
        end
      endcase
    end
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Control state machine for the multicycle RISC-V core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback over a shared PC/ALU/register-file datapath and a single unified instruction/data memory. It generates every datapath select/enable each cycle and stalls on a ready/request memory handshake. It sits beside the datapath in the top-level core, driven by the instruction register opcode and the ALU Zero flag.

## Interface
- No parameters; opcodes and encodings fixed below.
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- Op  in  7  opcode from instruction register
- funct3_0  in  1  instr[12]; 0 = BEQ, 1 = BNE
- Zero  in  1  ALU zero flag; sampled only in BRANCH
- mem_ready  in  1  memory completes current access this cycle; ignored when MemReq=0
- MemReq  out  1  memory access request
- MemWrite  out  1  store strobe; only asserted with MemReq
- AdrSrc  out  1  memory address: 0 = PC, 1 = Result
- IRWrite  out  1  load instruction register and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register file write
- ResultSrc  out  2  00 = ALUOut reg, 01 = memory data reg, 10 = ALU result (unregistered)
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  00 = add, 01 = branch compare (sub), 10 = R-type, 11 = I-type
- ImmSrc  out  2  combinational from Op in every state: 0100011 → 11 (S), 1100011 → 10 (B), 0010011/0000011/1100111 → 01 (I), else 00 (J)
- state  out  4  current state encoding (debug)
- illegal  out  1  high in TRAP

## Operation
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, LINK 12, TRAP 13. Encodings 14-15 go to FETCH next cycle with all controls 0.
- Unlisted controls are 0 in each state.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite are asserted only in the cycle mem_ready=1. Go to DECODE on mem_ready, else stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (OldPC+imm is latched in ALUOut). Next state by Op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - anything else → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if Op=0000011, else MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00. Go to MEMWB on mem_ready.
- MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1, ResultSrc=00. Go to FETCH on mem_ready.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=11. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite = Zero XOR funct3_0. Go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Go to ALUWB, which writes rd = OldPC+4.
- JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCWrite=1. Go to LINK.
- LINK: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Go to ALUWB.
- TRAP: all controls 0, illegal=1. Held until rst.

## Timing
- While rst=1: all outputs 0 except state=0; the next state is FETCH. Reset mid-access drops MemReq in the same cycle; a pending access is abandoned and not retried.
- Outputs are Moore decodes of state, except IRWrite/PCWrite in FETCH, which are also gated by mem_ready, and PCWrite in BRANCH, which is gated by Zero/funct3_0.
- Zero-wait latency in cycles, FETCH to next FETCH:
  - R, I, store, JAL: 4
  - load, JALR: 5
  - branch: 3
- Each extra cycle mem_ready is low adds one cycle. While waiting, all outputs hold their values.
- mem_ready high while MemReq=0 has no effect.
- MemReq and MemWrite are never high in the same cycle as RegWrite.
- In JALR, rs1 is read before the rd write in ALUWB, so rd==rs1 is handled correctly.

## Test plan
- Reset, then Op=0110011 with mem_ready=1 → states 0,1,6,8,0; RegWrite=1 only in state 8; ALUOp=10 in state 6.
- Load (Op=0000011) with mem_ready low for 2 cycles in FETCH and 1 in MEMREAD → states 0,0,0,1,2,3,3,4,0; IRWrite=1 exactly once; RegWrite with ResultSrc=01 in state 4.
- Store Op=0100011 → MEMWRITE asserts MemReq=1, MemWrite=1, AdrSrc=1, ImmSrc=11; no RegWrite during the whole instruction.
- BEQ with Zero=1 → PCWrite=1 in BRANCH. BNE (funct3_0=1) with Zero=1 → PCWrite=0. Each is 3 cycles.
- JAL → 4 cycles, PCWrite in state 10, RegWrite in state 8. JALR → states 11,12,8 with ResultSrc=10 in state 11.
- Op=1111111 → TRAP, illegal=1 held for 10 cycles. Then assert rst while in MEMREAD with MemReq=1 → all outputs 0 during rst; FETCH follows.
